// File: rtl/dmem_arb.sv
// ============================================================================
// Module   : dmem_arb
// Purpose  : Round-robin arbiter granting two requesters one-at-a-time access
//            to a single-ported 32-bit data memory with registered read data.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module dmem_arb #(
    parameter int DEPTH = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        p0_req,
    input  logic        p0_we,
    input  logic [31:0] p0_addr,
    input  logic [31:0] p0_wdata,
    input  logic        p1_req,
    input  logic        p1_we,
    input  logic [31:0] p1_addr,
    input  logic [31:0] p1_wdata,
    output logic        p0_ack,
    output logic        p0_err,
    output logic [31:0] p0_rdata,
    output logic        p1_ack,
    output logic        p1_err,
    output logic [31:0] p1_rdata,
    output logic        mem_dwe,
    output logic [31:0] mem_rr,
    output logic [31:0] mem_wr,
    output logic [31:0] mem_w,
    input  logic [31:0] mem_r,
    output logic        busy
);

    localparam logic [31:0] c_limit = 32'(4 * DEPTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        CAPT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t      r_state;
    logic        r_ptr;
    logic        r_id;
    logic        r_we;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [31:0] r_p0_rdata;
    logic [31:0] r_p1_rdata;

    logic        w_sel;
    logic        w_gnt_we;
    logic [31:0] w_gnt_addr;
    logic [31:0] w_gnt_wdata;
    logic        w_lat_err;

    function automatic logic addr_bad(input logic [31:0] a);
        return (a[1:0] != 2'b00) || (a >= c_limit);
    endfunction

    // A lone requester wins outright; the pointer only breaks ties.
    always_comb begin
        w_sel       = 1'b0;
        w_gnt_we    = p0_we;
        w_gnt_addr  = p0_addr;
        w_gnt_wdata = p0_wdata;
        if (p0_req && p1_req) begin
            w_sel = r_ptr;
        end else begin
            w_sel = p1_req;
        end
        if (w_sel) begin
            w_gnt_we    = p1_we;
            w_gnt_addr  = p1_addr;
            w_gnt_wdata = p1_wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_ptr      <= 1'b0;
            r_id       <= 1'b0;
            r_we       <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_p0_rdata <= '0;
            r_p1_rdata <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (p0_req || p1_req) begin
                        r_id    <= w_sel;
                        r_we    <= w_gnt_we;
                        r_addr  <= w_gnt_addr;
                        r_wdata <= w_gnt_wdata;
                        r_ptr   <= ~w_sel;
                        r_state <= addr_bad(w_gnt_addr) ? RESP : ISSUE;
                    end
                end
                ISSUE: begin
                    r_state <= r_we ? RESP : CAPT;
                end
                CAPT: begin
                    if (r_id) begin
                        r_p1_rdata <= mem_r;
                    end else begin
                        r_p0_rdata <= mem_r;
                    end
                    r_state <= RESP;
                end
                RESP: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    // Outputs decode directly from state so an async reset clears them at once.
    assign w_lat_err = addr_bad(r_addr);
    assign busy      = (r_state != IDLE);
    assign mem_dwe   = (r_state == ISSUE) && r_we;
    assign mem_rr    = r_addr;
    assign mem_wr    = r_addr;
    assign mem_w     = r_wdata;
    assign p0_ack    = (r_state == RESP) && !r_id;
    assign p1_ack    = (r_state == RESP) && r_id;
    assign p0_err    = p0_ack && w_lat_err;
    assign p1_err    = p1_ack && w_lat_err;
    assign p0_rdata  = r_p0_rdata;
    assign p1_rdata  = r_p1_rdata;

endmodule

`default_nettype wire

// File: doc/dmem_arb.md
DMEM_ARB -- requirements
Module: dmem_arb

Interface
REQ-001 SHALL have parameter DEPTH, default 8, meaning number of 32-bit data-memory words; legal byte addresses are 0 .. 4*DEPTH-1.
REQ-002 SHALL have port clk, input, 1 bit: single clock; all state updates on posedge.
REQ-003 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-004 SHALL have, for each requester port n in {0,1}, the following signals:
- pn_req, input, 1: request.
- pn_we, input, 1: 1 = store, 0 = load.
- pn_addr, input, 32: byte address.
- pn_wdata, input, 32: store data.
REQ-005 SHALL have, for n in {0,1}, the following signals:
- pn_ack, output, 1: one-cycle completion pulse.
- pn_err, output, 1: error flag, valid with pn_ack.
- pn_rdata, output, 32: load data, registered.
REQ-006 SHALL have the following memory-side signals:
- mem_dwe, output, 1: write enable to data memory.
- mem_rr, output, 32: read byte address.
- mem_wr, output, 32: write byte address.
- mem_w, output, 32: write data.
- mem_r, input, 32: memory read data, registered by the memory one edge after the address.
REQ-007 SHALL have port busy, output, 1: high whenever state is not IDLE.

Function
REQ-008 SHALL implement FSM states IDLE, ISSUE, CAPT, RESP; only one access in flight.
REQ-009 In IDLE, SHALL sample pn_req on each posedge; no request -> stay in IDLE.
REQ-010 If exactly one request is present in IDLE, SHALL grant it.
REQ-011 If both requests are present in IDLE, SHALL grant the port named by the round-robin pointer.
REQ-012 After every grant, including error grants, SHALL set the round-robin pointer to the other port.
REQ-013 On grant, SHALL latch port id, we, addr, and wdata into internal registers; requester fields are ignored thereafter until pn_ack.
REQ-014 SHALL flag an error when the latched addr[1:0] != 0 or the address >= 4*DEPTH.
REQ-015 On an error grant, SHALL go IDLE -> RESP with no memory write (mem_dwe stays 0).
REQ-016 Otherwise, SHALL go IDLE -> ISSUE.
REQ-017 In ISSUE, SHALL drive mem_dwe = latched we for exactly one cycle.
REQ-018 mem_rr, mem_wr, and mem_w SHALL continuously reflect the latched addr/addr/wdata registers.
REQ-019 From ISSUE, a store SHALL go to RESP and a load SHALL go to CAPT.
REQ-020 In CAPT, SHALL load mem_r into the granted port's pn_rdata at the end of the cycle, then go to RESP.
REQ-021 In RESP, SHALL assert pn_ack=1 for the granted port only, for exactly one cycle, with pn_err per REQ-014, then return to IDLE.
REQ-022 Ack latency from the sampling edge SHALL be:
- Load: ack in 3rd cycle.
- Store: ack in 2nd cycle.
- Error: ack in 1st cycle.
REQ-023 pn_rdata SHALL change only in CAPT for its own port; stores and errors leave it unchanged.
REQ-024 Requests arriving while busy SHALL be ignored until the next IDLE sample.
REQ-025 The requester SHALL hold pn_req and fields stable until pn_ack; a pn_req still high in the IDLE cycle after ack is treated as a new request.
REQ-026 pn_req dropped before grant SHALL cause no access.
REQ-027 Only state, latched registers, and pn_rdata SHALL be sequential.

Reset
REQ-028 When rst=1, SHALL asynchronously force the following values:
- State IDLE, pointer = port 0.
- Latched addr/wdata = 0, we = 0.
- mem_dwe = 0, busy = 0.
- pn_ack = 0, pn_err = 0, pn_rdata = 0.
REQ-029 Reset mid-operation SHALL abandon the access with no ack and no further memory write; a write already sampled by memory is not undone.
REQ-030 The first IDLE sample SHALL occur on the first posedge after rst deasserts.

Verification
REQ-031 Single load: memory word 2 = 0xDEADBEEF; p0 load addr 0x8 -> p0_ack in 3rd cycle, p0_err=0, p0_rdata=0xDEADBEEF, p1_ack never asserted.
REQ-032 Single store: p1 store addr 0x4, wdata 0x12345678 -> mem_dwe=1 for exactly one cycle with mem_wr=0x4, mem_w=0x12345678; p1_ack in 2nd cycle; subsequent load of 0x4 returns 0x12345678.
REQ-033 Conflict: p0 and p1 request loads in the same cycle after reset -> p0 served first, p1 acked one transaction later; repeated simultaneous requests alternate 1,0,1.
REQ-034 Errors: p0 load 0x6 -> ack in 1st cycle with p0_err=1; p1 store 0x20 (DEPTH=8) -> p1_err=1, mem_dwe never 1, memory unchanged, p1_rdata unchanged.
REQ-035 Reset mid-op: assert rst during ISSUE of a p0 load -> busy=0 and mem_dwe=0 immediately, no p0_ack, pointer=0; a new request after release completes normally.
REQ-036 Back-to-back: p0 holds req after ack with a new addr 0x0 -> second access granted in the IDLE cycle following RESP, and no request is lost or duplicated.
